// File: rtl/scpad_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : scpad_tile_sequencer
// Description : Walks a scratchpad tile one row or column per beat and emits
//               swizzle descriptors, then signals tile completion.
// Revision    : 1.0 - initial release
// ============================================================================
module scpad_tile_sequencer #(
  parameter int NUM_COLS      = 32,
  parameter int ROW_IDX_WIDTH = 10,
  parameter int COL_IDX_WIDTH = $clog2(NUM_COLS),
  parameter int ID_WIDTH      = 4
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ROW_IDX_WIDTH-1:0] req_spad_addr,
  input  logic [COL_IDX_WIDTH:0]   req_num_rows,
  input  logic [COL_IDX_WIDTH:0]   req_num_cols,
  input  logic                     req_row_or_col,
  input  logic [ID_WIDTH-1:0]      req_id,
  input  logic                     abort,
  output logic                     beat_valid,
  input  logic                     beat_ready,
  output logic [ROW_IDX_WIDTH-1:0] beat_spad_addr,
  output logic [COL_IDX_WIDTH-1:0] beat_row_id,
  output logic [COL_IDX_WIDTH-1:0] beat_col_id,
  output logic [COL_IDX_WIDTH:0]   beat_num_rows,
  output logic [COL_IDX_WIDTH:0]   beat_num_cols,
  output logic                     beat_row_or_col,
  output logic [ID_WIDTH-1:0]      beat_id,
  output logic                     beat_last,
  output logic                     done_valid,
  output logic [ID_WIDTH-1:0]      done_id,
  output logic                     busy
);

  localparam logic [COL_IDX_WIDTH:0] c_MAX_CNT = (COL_IDX_WIDTH+1)'(NUM_COLS);
  localparam logic [COL_IDX_WIDTH:0] c_ONE     = (COL_IDX_WIDTH+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [ROW_IDX_WIDTH-1:0] r_spad_addr;
  logic [COL_IDX_WIDTH:0]   r_num_rows;
  logic [COL_IDX_WIDTH:0]   r_num_cols;
  logic                     r_row_or_col;
  logic [ID_WIDTH-1:0]      r_id;
  logic [COL_IDX_WIDTH:0]   r_cnt;

  logic [COL_IDX_WIDTH:0]   w_rows_clamp;
  logic [COL_IDX_WIDTH:0]   w_cols_clamp;
  logic [COL_IDX_WIDTH:0]   w_req_n;
  logic [COL_IDX_WIDTH:0]   w_n;
  logic [COL_IDX_WIDTH:0]   w_cnt_inc;
  logic                     w_accept;
  logic                     w_xfer;
  logic                     w_last;

  assign w_rows_clamp = (req_num_rows > c_MAX_CNT) ? c_MAX_CNT : req_num_rows;
  assign w_cols_clamp = (req_num_cols > c_MAX_CNT) ? c_MAX_CNT : req_num_cols;
  assign w_req_n      = req_row_or_col ? w_rows_clamp : w_cols_clamp;
  assign w_n          = r_row_or_col ? r_num_rows : r_num_cols;
  assign w_cnt_inc    = r_cnt + c_ONE;
  assign w_accept     = (r_state == S_IDLE) && req_valid;
  assign w_xfer       = (r_state == S_ISSUE) && beat_ready;
  // Counter stays below N, so cnt+1 never exceeds NUM_COLS and cannot wrap.
  assign w_last       = (w_cnt_inc == w_n);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_state_nxt = (w_req_n == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: begin
        if (abort)                w_state_nxt = S_IDLE;
        else if (w_xfer && w_last) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_spad_addr  <= '0;
      r_num_rows   <= '0;
      r_num_cols   <= '0;
      r_row_or_col <= 1'b0;
      r_id         <= '0;
      r_cnt        <= '0;
    end else if (w_accept) begin
      r_spad_addr  <= req_spad_addr;
      r_num_rows   <= w_rows_clamp;
      r_num_cols   <= w_cols_clamp;
      r_row_or_col <= req_row_or_col;
      r_id         <= req_id;
      r_cnt        <= '0;
    end else if (w_xfer && !w_last) begin
      r_cnt <= w_cnt_inc;
    end
  end

  assign req_ready       = (r_state == S_IDLE);
  assign busy            = (r_state != S_IDLE);
  assign beat_valid      = (r_state == S_ISSUE);
  assign beat_spad_addr  = r_spad_addr;
  assign beat_row_id     = r_row_or_col ? r_cnt[COL_IDX_WIDTH-1:0] : '0;
  assign beat_col_id     = r_row_or_col ? '0 : r_cnt[COL_IDX_WIDTH-1:0];
  assign beat_num_rows   = r_num_rows;
  assign beat_num_cols   = r_num_cols;
  assign beat_row_or_col = r_row_or_col;
  assign beat_id         = r_id;
  assign beat_last       = (r_state == S_ISSUE) && w_last;
  assign done_valid      = (r_state == S_DONE);
  assign done_id         = r_id;

endmodule
`default_nettype wire

// File: tb/tb_scpad_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_scpad_tile_sequencer
// Description : Directed vector bench for scpad_tile_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scpad_tile_sequencer;

  localparam int NC = 32;
  localparam int RW = 10;
  localparam int CW = 5;
  localparam int IW = 4;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [RW-1:0] req_spad_addr = '0;
  logic [CW:0]   req_num_rows = '0;
  logic [CW:0]   req_num_cols = '0;
  logic          req_row_or_col = 1'b0;
  logic [IW-1:0] req_id = '0;
  logic          abort = 1'b0;
  logic          beat_valid;
  logic          beat_ready = 1'b0;
  logic [RW-1:0] beat_spad_addr;
  logic [CW-1:0] beat_row_id;
  logic [CW-1:0] beat_col_id;
  logic [CW:0]   beat_num_rows;
  logic [CW:0]   beat_num_cols;
  logic          beat_row_or_col;
  logic [IW-1:0] beat_id;
  logic          beat_last;
  logic          done_valid;
  logic [IW-1:0] done_id;
  logic          busy;

  int n_run  = 0;
  int n_fail = 0;

  scpad_tile_sequencer #(
    .NUM_COLS(NC), .ROW_IDX_WIDTH(RW), .COL_IDX_WIDTH(CW), .ID_WIDTH(IW)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_spad_addr(req_spad_addr), .req_num_rows(req_num_rows),
    .req_num_cols(req_num_cols), .req_row_or_col(req_row_or_col),
    .req_id(req_id), .abort(abort),
    .beat_valid(beat_valid), .beat_ready(beat_ready),
    .beat_spad_addr(beat_spad_addr), .beat_row_id(beat_row_id),
    .beat_col_id(beat_col_id), .beat_num_rows(beat_num_rows),
    .beat_num_cols(beat_num_cols), .beat_row_or_col(beat_row_or_col),
    .beat_id(beat_id), .beat_last(beat_last),
    .done_valid(done_valid), .done_id(done_id), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [RW-1:0] addr;
    logic [CW:0]   rows;
    logic [CW:0]   cols;
    logic          rm;
    logic [IW-1:0] id;
    int            exp_n;
    logic [CW:0]   exp_rows;
    logic [CW:0]   exp_cols;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_req(input vec_t v);
    int w;
    req_spad_addr  = v.addr;
    req_num_rows   = v.rows;
    req_num_cols   = v.cols;
    req_row_or_col = v.rm;
    req_id         = v.id;
    req_valid      = 1'b1;
    w = 0;
    while (!req_ready && w < 20) begin
      @(posedge CLK); #1;
      w++;
    end
    if (w >= 20) chk("req_ready_timeout", 64'(req_ready), 64'd1);
    @(posedge CLK); #1;
    req_valid = 1'b0;
  endtask

  // Drives beat_ready from mask (bit i = cycle i+1 after acceptance) and
  // checks every beat against the expected walk.
  task automatic run_tile(input vec_t v, input logic [15:0] mask);
    int xfers, dones, first_beat, done_cyc, ready_cyc;
    logic pv_stall, stopped;
    logic [63:0] prev, cur;
    xfers = 0; dones = 0; first_beat = -1; done_cyc = -1; ready_cyc = -1;
    pv_stall = 1'b0; stopped = 1'b0; prev = '0;
    for (int cyc = 1; cyc < 100; cyc++) begin
      beat_ready = (cyc <= 16) ? mask[cyc-1] : 1'b1;
      @(negedge CLK);
      cur = 64'({beat_spad_addr, beat_row_id, beat_col_id, beat_num_rows,
                 beat_num_cols, beat_row_or_col, beat_id, beat_last});
      if (beat_valid) begin
        if (first_beat < 0) first_beat = cyc;
        if (pv_stall) chk("stall_hold", cur, prev);
        if (beat_ready) begin
          chk("row_id", 64'(beat_row_id), v.rm ? 64'(xfers) : 64'd0);
          chk("col_id", 64'(beat_col_id), v.rm ? 64'd0 : 64'(xfers));
          chk("last", 64'(beat_last), 64'(xfers == v.exp_n - 1));
          chk("beat_spad", 64'(beat_spad_addr), 64'(v.addr));
          chk("beat_id", 64'(beat_id), 64'(v.id));
          xfers++;
        end
        pv_stall = !beat_ready;
        prev = cur;
      end else begin
        pv_stall = 1'b0;
      end
      if (done_valid) begin
        dones++;
        done_cyc = cyc;
        chk("done_id", 64'(done_id), 64'(v.id));
        chk("num_rows", 64'(beat_num_rows), 64'(v.exp_rows));
        chk("num_cols", 64'(beat_num_cols), 64'(v.exp_cols));
        chk("row_or_col", 64'(beat_row_or_col), 64'(v.rm));
      end
      if (done_cyc > 0 && cyc > done_cyc && req_ready) begin
        ready_cyc = cyc;
        stopped = 1'b1;
        break;
      end
      @(posedge CLK); #1;
    end
    if (stopped) begin
      @(posedge CLK); #1;
    end
    beat_ready = 1'b0;
    chk("tile_timeout", 64'(stopped), 64'd1);
    chk("xfer_count", 64'(xfers), 64'(v.exp_n));
    chk("done_count", 64'(dones), 64'd1);
    if (mask == 16'hFFFF) begin
      chk("first_beat_cyc", 64'(first_beat), (v.exp_n > 0) ? 64'd1 : 64'hFFFF_FFFF_FFFF_FFFF);
      chk("done_cyc", 64'(done_cyc), 64'(v.exp_n + 1));
      chk("ready_cyc", 64'(ready_cyc), 64'(v.exp_n + 2));
    end
  endtask

  vec_t vecs[6];
  vec_t va, vr, vs;

  initial begin
    vecs[0] = '{addr:10'd100, rows:6'd4,  cols:6'd32, rm:1'b1, id:4'd3,  exp_n:4,  exp_rows:6'd4,  exp_cols:6'd32};
    vecs[1] = '{addr:10'd5,   rows:6'd40, cols:6'd7,  rm:1'b1, id:4'd9,  exp_n:32, exp_rows:6'd32, exp_cols:6'd7};
    vecs[2] = '{addr:10'd17,  rows:6'd0,  cols:6'd5,  rm:1'b1, id:4'd6,  exp_n:0,  exp_rows:6'd0,  exp_cols:6'd5};
    vecs[3] = '{addr:10'd1023,rows:6'd2,  cols:6'd5,  rm:1'b0, id:4'd12, exp_n:5,  exp_rows:6'd2,  exp_cols:6'd5};
    vecs[4] = '{addr:10'd64,  rows:6'd63, cols:6'd33, rm:1'b0, id:4'd15, exp_n:32, exp_rows:6'd32, exp_cols:6'd32};
    vecs[5] = '{addr:10'd300, rows:6'd8,  cols:6'd0,  rm:1'b0, id:4'd1,  exp_n:0,  exp_rows:6'd8,  exp_cols:6'd0};
    va = '{addr:10'd7,   rows:6'd8, cols:6'd2, rm:1'b1, id:4'd5,  exp_n:8, exp_rows:6'd8, exp_cols:6'd2};
    vr = '{addr:10'd200, rows:6'd8, cols:6'd4, rm:1'b1, id:4'd11, exp_n:8, exp_rows:6'd8, exp_cols:6'd4};
    vs = '{addr:10'd42,  rows:6'd1, cols:6'd3, rm:1'b0, id:4'd10, exp_n:3, exp_rows:6'd1, exp_cols:6'd3};

    // Reset values
    #12;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_beat_valid", 64'(beat_valid), 64'd0);
    chk("rst_done_valid", 64'(done_valid), 64'd0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(posedge CLK); #1;

    for (int i = 0; i < 6; i++) begin
      do_req(vecs[i]);
      run_tile(vecs[i], 16'hFFFF);
    end

    // Column-major with stalls: ready 1,0,0,1,1
    do_req(vs);
    run_tile(vs, 16'b1111_1111_1111_1001 | 16'h0010 | 16'h0008);

    // Abort on second beat; abort in IDLE must not block acceptance
    abort = 1'b1;
    do_req(va);
    abort = 1'b0;
    beat_ready = 1'b1;
    chk("abort_idle_ignored", 64'(busy), 64'd1);
    @(negedge CLK);
    chk("abort_b0_row", 64'(beat_row_id), 64'd0);
    @(posedge CLK); #1;
    abort = 1'b1;
    @(negedge CLK);
    chk("abort_b1_valid", 64'(beat_valid), 64'd1);
    chk("abort_b1_row", 64'(beat_row_id), 64'd1);
    @(posedge CLK); #1;
    abort = 1'b0;
    beat_ready = 1'b0;
    chk("abort_idle_ready", 64'(req_ready), 64'd1);
    chk("abort_idle_busy", 64'(busy), 64'd0);
    chk("abort_no_beat", 64'(beat_valid), 64'd0);
    for (int k = 0; k < 3; k++) begin
      chk("abort_no_done", 64'(done_valid), 64'd0);
      @(posedge CLK); #1;
    end
    do_req(vecs[0]);
    run_tile(vecs[0], 16'hFFFF);

    // Reset during beat 5
    do_req(vr);
    beat_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      @(posedge CLK); #1;
    end
    @(negedge CLK);
    chk("rst_mid_row", 64'(beat_row_id), 64'd4);
    #2 nRST = 1'b0;
    #1;
    chk("rstm_req_ready", 64'(req_ready), 64'd1);
    chk("rstm_busy", 64'(busy), 64'd0);
    chk("rstm_beat_valid", 64'(beat_valid), 64'd0);
    chk("rstm_fields", 64'({beat_spad_addr, beat_row_id, beat_num_rows, beat_id, beat_last}), 64'd0);
    chk("rstm_done", 64'({done_valid, done_id}), 64'd0);
    beat_ready = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    for (int k = 0; k < 2; k++) begin
      chk("rstm_no_done", 64'(done_valid), 64'd0);
      @(posedge CLK); #1;
    end
    do_req(vecs[3]);
    run_tile(vecs[3], 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
